// File: rtl/async_sram_ctrl.sv
// async_sram_ctrl: single-beat (optionally burst-read) controller for an
// asynchronous SRAM. Each request becomes SETUP -> ACCESS x WAIT_CYC ->
// HOLD (writes) or TURN x TURN_CYC (reads). All SRAM strobes are registered
// from the next-state decode, so they change cleanly on clock edges.
//
// Optional feature macro: SRAM_BURST_EN (adds req_len for burst reads).
//
// Ports:
//   sys_clk, sys_rst_n      clock, asynchronous active-low reset
//   enable                  controller enable; gates request acceptance
//   req_valid/req_ready     request handshake
//   req_we, req_addr,
//   req_wdata               request fields (req_we=1 means write)
//   req_len                 burst length minus 1 (SRAM_BURST_EN only)
//   rsp_valid, rsp_rdata    one-cycle read data strobe and held read data
//   busy                    high whenever the FSM is not idle
//   sram_addr, sram_dq_o,
//   sram_dq_oe, sram_dq_i   SRAM address and split data bus (tristate outside)
//   sram_ce_n, sram_we_n,
//   sram_oe_n               SRAM active-low strobes
module async_sram_ctrl #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 8,
  parameter int WAIT_CYC = 2,
  parameter int TURN_CYC = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              enable,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef SRAM_BURST_EN
  input  logic [3:0]        req_len,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    TURN   = 3'd4
  } state_t;

  // Counters are loaded with (cycles - 1) and count down to zero.
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC - 1);
  localparam logic [3:0] TURN_LD = (TURN_CYC > 0) ? 4'(TURN_CYC - 1) : 4'd0;

  state_t              state_r, state_nxt_s;
  logic [3:0]          cnt_r, cnt_nxt_s;
  logic [3:0]          beats_r, beats_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
  logic [DATA_W-1:0]   wdata_r, wdata_nxt_s;
  logic                we_r, we_nxt_s;
  logic [1:0]          rst_sync_r;
  logic                accept_s;
  logic                capture_s;
  logic [3:0]          len_s;
  logic                ce_n_nxt_s, we_n_nxt_s, oe_n_nxt_s, dq_oe_nxt_s, busy_nxt_s;
  logic                sram_ce_n_r, sram_we_n_r, sram_oe_n_r, sram_dq_oe_r;
  logic                rsp_valid_r, busy_r;
  logic [DATA_W-1:0]   rsp_rdata_r;

`ifdef SRAM_BURST_EN
  assign len_s = req_len;
`else
  assign len_s = 4'd0;
`endif

  // Requests are refused until the synchronised reset release reaches stage 2.
  assign req_ready = rst_sync_r[1] && enable && (state_r == IDLE);
  assign accept_s  = req_valid && req_ready;

  // Reset-release synchroniser: asserts asynchronously, releases over two edges.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  // Next-state decode, operation latching, beat sequencing and read capture.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    beats_nxt_s = beats_r;
    addr_nxt_s  = addr_r;
    wdata_nxt_s = wdata_r;
    we_nxt_s    = we_r;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = SETUP;
          addr_nxt_s  = req_addr;
          wdata_nxt_s = req_wdata;
          we_nxt_s    = req_we;
          // Writes are always single beat.
          beats_nxt_s = req_we ? 4'd0 : len_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP: begin
        state_nxt_s = ACCESS;
        cnt_nxt_s   = WAIT_LD;
      end
      ACCESS: begin
        if (cnt_r == 4'd0) begin
          if (we_r) begin
            state_nxt_s = HOLD;
          end else begin
            capture_s = 1'b1;
            if (beats_r != 4'd0) begin
              // Next burst beat; address wraps naturally at 2^ADDR_W.
              state_nxt_s = SETUP;
              beats_nxt_s = beats_r - 4'd1;
              addr_nxt_s  = addr_r + ADDR_W'(1);
            end else if (TURN_CYC == 0) begin
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = TURN;
              cnt_nxt_s   = TURN_LD;
            end
          end
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      HOLD: begin
        state_nxt_s = IDLE;
      end
      TURN: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // SRAM strobe decode for the upcoming state; oe_n and dq_oe are mutually
  // exclusive because oe_n is only low for reads and dq_oe only high for writes.
  always_comb begin
    ce_n_nxt_s  = 1'b1;
    we_n_nxt_s  = 1'b1;
    oe_n_nxt_s  = 1'b1;
    dq_oe_nxt_s = 1'b0;
    busy_nxt_s  = (state_nxt_s != IDLE);
    case (state_nxt_s)
      SETUP: begin
        ce_n_nxt_s  = 1'b0;
        oe_n_nxt_s  = we_nxt_s;
        dq_oe_nxt_s = we_nxt_s;
      end
      ACCESS: begin
        ce_n_nxt_s  = 1'b0;
        we_n_nxt_s  = !we_nxt_s;
        oe_n_nxt_s  = we_nxt_s;
        dq_oe_nxt_s = we_nxt_s;
      end
      HOLD: begin
        ce_n_nxt_s  = 1'b0;
        dq_oe_nxt_s = we_nxt_s;
      end
      default: begin
        ce_n_nxt_s  = 1'b1;
      end
    endcase
  end

  // State, operation registers and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      beats_r      <= 4'd0;
      addr_r       <= '0;
      wdata_r      <= '0;
      we_r         <= 1'b0;
      sram_ce_n_r  <= 1'b1;
      sram_we_n_r  <= 1'b1;
      sram_oe_n_r  <= 1'b1;
      sram_dq_oe_r <= 1'b0;
      busy_r       <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_rdata_r  <= '0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      beats_r      <= beats_nxt_s;
      addr_r       <= addr_nxt_s;
      wdata_r      <= wdata_nxt_s;
      we_r         <= we_nxt_s;
      sram_ce_n_r  <= ce_n_nxt_s;
      sram_we_n_r  <= we_n_nxt_s;
      sram_oe_n_r  <= oe_n_nxt_s;
      sram_dq_oe_r <= dq_oe_nxt_s;
      busy_r       <= busy_nxt_s;
      rsp_valid_r  <= capture_s;
      if (capture_s) begin
        rsp_rdata_r <= sram_dq_i;
      end else begin
        rsp_rdata_r <= rsp_rdata_r;
      end
    end
  end

  assign sram_addr  = addr_r;
  assign sram_dq_o  = wdata_r;
  assign sram_ce_n  = sram_ce_n_r;
  assign sram_we_n  = sram_we_n_r;
  assign sram_oe_n  = sram_oe_n_r;
  assign sram_dq_oe = sram_dq_oe_r;
  assign busy       = busy_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_rdata  = rsp_rdata_r;

endmodule

// File: doc/async_sram_ctrl.md
ASYNC_SRAM_CTRL -- requirements
Module: async_sram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 15, SHALL set the SRAM address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the SRAM data width.
REQ-003 Parameter WAIT_CYC, default 2, range 1..15, SHALL set the number of ACCESS cycles per beat.
REQ-004 Parameter TURN_CYC, default 1, range 0..7, SHALL set the number of bus-turnaround cycles after each read.
REQ-005 Ports, in order: sys_clk in 1 (single clock); sys_rst_n in 1 (reset, asynchronous, active-low).
REQ-006 Request ports: enable in 1 (controller enable); req_valid in 1; req_ready out 1; req_we in 1 (1=write); req_addr in ADDR_W; req_wdata in DATA_W.
REQ-007 Response and status ports: rsp_valid out 1 (read data strobe); rsp_rdata out DATA_W; busy out 1.
REQ-008 SRAM ports: sram_addr out ADDR_W; sram_dq_o out DATA_W; sram_dq_oe out 1; sram_dq_i in DATA_W; sram_ce_n, sram_we_n, sram_oe_n out 1 each. Tristate buffers live outside the block.

Function
REQ-009 The FSM SHALL have states IDLE, SETUP, ACCESS, HOLD, TURN.
REQ-010 req_ready SHALL equal (state==IDLE && enable); a request is accepted on an edge where req_valid && req_ready.
REQ-011 On accept, the block SHALL register addr, we and wdata, then go to SETUP for 1 cycle with sram_ce_n=0.
REQ-012 Write in SETUP: sram_dq_oe=1, sram_we_n=1. Write in ACCESS: sram_we_n=0 for WAIT_CYC cycles. Write in HOLD: 1 cycle with sram_we_n=1 and data still driven. The block then returns to IDLE.
REQ-013 Read: sram_oe_n=0 from SETUP through the last ACCESS cycle; sram_dq_oe=0 throughout.
REQ-014 Read data: sram_dq_i SHALL be registered at the end of the last ACCESS cycle into rsp_rdata.
REQ-015 Read response: rsp_valid SHALL pulse for exactly 1 cycle in the following cycle, i.e. 2+WAIT_CYC cycles after the accept edge.
REQ-016 After each read, the block SHALL spend TURN_CYC cycles in TURN with ce_n/oe_n/we_n=1 and dq_oe=0 before IDLE. When TURN_CYC=0, TURN is skipped.
REQ-017 sram_we_n and sram_oe_n SHALL never both be 0. sram_dq_oe SHALL never be 1 while sram_oe_n=0.
REQ-018 busy SHALL be high in every state except IDLE.
REQ-019 When enable deasserts mid-operation, the current operation SHALL complete and no new request SHALL be accepted.
REQ-020 rsp_rdata SHALL hold its last value until the next read capture.

Reset
REQ-021 While sys_rst_n=0, the block SHALL asynchronously force: state=IDLE; sram_ce_n, sram_we_n, sram_oe_n=1; sram_dq_oe=0; sram_addr, sram_dq_o, rsp_rdata=0; rsp_valid, busy, req_ready=0.
REQ-022 Reset asserted mid-operation SHALL abort that operation with no rsp_valid.
REQ-023 Reset release SHALL be synchronised inside the block, and the first accept SHALL occur no earlier than the second rising edge after release.

Configuration
REQ-024 Macro SRAM_BURST_EN SHALL add input req_len[3:0], carrying the burst length minus 1.
REQ-025 With SRAM_BURST_EN defined, a read with req_len=N SHALL perform N+1 SETUP/ACCESS beats at consecutive addresses, with address wraparound modulo 2^ADDR_W. Each beat SHALL produce one rsp_valid pulse, ce_n SHALL stay low between beats, and TURN SHALL occur once at the end.
REQ-026 With SRAM_BURST_EN defined, writes SHALL ignore req_len (single beat).
REQ-027 Without SRAM_BURST_EN, the req_len port SHALL be absent and every request SHALL be single-beat.

Verification
REQ-028 Defaults: write 0xA5 to address 0x0012 -> sram_we_n low exactly 2 cycles, dq_oe high 4 cycles, ce_n low 4 cycles, return to IDLE.
REQ-029 Read address 0x0012 with the model returning 0xA5 -> rsp_valid one cycle at accept+4 with rsp_rdata=0xA5; the next accept no earlier than accept+5.
REQ-030 Back-to-back read-then-write with req_valid held -> dq_oe rises only after TURN, and the we_n/oe_n overlap checker never fires.
REQ-031 sys_rst_n pulsed low during ACCESS of a write -> outputs reach their reset values without a clock edge, and no rsp_valid occurs.
REQ-032 SRAM_BURST_EN with read at 0x7FFE, req_len=3 -> 4 rsp_valid pulses at addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
REQ-033 enable dropped one cycle after accept -> the operation completes, and req_ready stays 0 until enable returns.
